// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar arbitration blocks.
//   arb_state_t : arbiter FSM state encoding
//   id_width()  : source-tag width for N ports, never less than 1
package crossbar_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/crossbar_rr_picker.sv
// Combinational rotating-priority select.
//   req        : per-port request vector
//   last_grant : index of the most recently served port
//   any_req    : at least one request is present
//   pick       : first requesting port scanning upward from last_grant+1 with wrap
module crossbar_rr_picker
  import crossbar_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  localparam int unsigned ID_WIDTH  = id_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  last_grant,
  output logic                 any_req,
  output logic [ID_WIDTH-1:0]  pick
);

  logic [ID_WIDTH-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    any_req = |req;
    pick    = '0;
    cand    = '0;
    for (int i = int'(NUM_PORTS); i >= 1; i--) begin
      cand = ID_WIDTH'((int'(last_grant) + i) % int'(NUM_PORTS));
      if (req[cand]) begin
        pick = cand;
      end
    end
  end

endmodule

// File: rtl/crossbar_rr_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS AXI-Stream sources onto one
// registered output stream tagged with the source index.
//   clk, resetn        : clock, asynchronous active-low reset
//   s_axis_tvalid/tlast: per-source valid / end of packet
//   s_axis_tdata       : flattened payloads, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tready      : per-source ready, only the granted port can be high
//   m_axis_*           : registered output beat with tid = source port
module crossbar_rr_arbiter
  import crossbar_pkg::*;
#(
  parameter  int unsigned NUM_PORTS  = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned ID_WIDTH   = id_width(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid
);

  arb_state_t            state;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   last_grant;
  logic                  any_req;
  logic [ID_WIDTH-1:0]   pick;
  logic                  grant_ready;
  logic                  grant_valid;
  logic                  grant_last;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  accept;

  crossbar_rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .pick       (pick)
  );

  // Output slot is free when empty or draining this cycle.
  assign grant_ready = (state == ARB_BUSY) && (!m_axis_tvalid || m_axis_tready);
  assign accept      = grant_ready && grant_valid;

  // Route the granted source and drive its ready; never looks at tvalid for ready.
  always_comb begin
    s_axis_tready = '0;
    grant_valid   = 1'b0;
    grant_last    = 1'b0;
    grant_data    = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (grant == ID_WIDTH'(i)) begin
        s_axis_tready[i] = grant_ready;
        grant_valid      = s_axis_tvalid[i];
        grant_last       = s_axis_tlast[i];
        grant_data       = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration FSM and output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ARB_IDLE;
      grant         <= '0;
      last_grant    <= ID_WIDTH'(NUM_PORTS - 1);
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else begin
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= grant_data;
        m_axis_tlast  <= grant_last;
        m_axis_tid    <= grant;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant <= pick;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (accept && grant_last) begin
            last_grant <= grant;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/crossbar_rr_arbiter.md
# crossbar_rr_arbiter

Packet-level round-robin arbiter that merges `NUM_PORTS` AXI-Stream requesters onto one shared output stream. It typically feeds a shared `crossbar_fifo` or downstream crossbar port. A grant is held for a whole packet, from the first beat through the beat with `tlast`. The output is registered and tagged with the source port index.

## Interface
- `NUM_PORTS`, 4, number of requesters (≥1)
- `DATA_WIDTH`, 32, payload width per beat
- `ID_WIDTH`, `$clog2(NUM_PORTS)` (min 1), width of source tag; derived, not overridden
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  reset, asynchronous and active-low
- `s_axis_tvalid`  in  NUM_PORTS  per-requester valid
- `s_axis_tready`  out  NUM_PORTS  per-requester ready; at most one bit high
- `s_axis_tdata`  in  NUM_PORTS*DATA_WIDTH  flattened payload; port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `s_axis_tlast`  in  NUM_PORTS  per-requester end of packet
- `m_axis_tvalid`  out  1  output valid
- `m_axis_tready`  in  1  output ready
- `m_axis_tdata`  out  DATA_WIDTH  output payload
- `m_axis_tlast`  out  1  output end of packet
- `m_axis_tid`  out  ID_WIDTH  index of the granted source port

## Operation
- FSM states: `ARB_IDLE`, `ARB_BUSY`.
- **`ARB_IDLE` state**
  - All `s_axis_tready` are 0.
  - If any `s_axis_tvalid` is set, select the first valid port scanning from `(last_grant+1) mod NUM_PORTS` upward with wrap.
  - Register the selection as `grant` and go to `ARB_BUSY`.
  - `tvalid` is sampled only; no beat is consumed in this state.
- **`ARB_BUSY` state**
  - `s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready`. All other ready bits are 0.
- **Accepted beat** (`s_axis_tvalid[grant] & s_axis_tready[grant]`)
  - Output register loads tdata, tlast and `tid = grant`, and `m_axis_tvalid <= 1`.
  - If tlast is set: `last_grant <= grant`, go to `ARB_IDLE`.
- **Output register**
  - When `m_axis_tready` is high and no new beat is loaded, `m_axis_tvalid <= 0`.
  - While `m_axis_tvalid & ~m_axis_tready`, tdata, tlast and tid are held stable.
- **Grant hold**
  - The grant never changes mid-packet, even if the granted port deasserts tvalid or other ports request.
  - Non-granted ports see ready=0 and must hold their beat.
- **Fairness:** a continuously requesting port waits at most NUM_PORTS−1 packets.
- **`NUM_PORTS=1`:** the same FSM applies and tid is always 0.
- **Reset values** (asynchronous, immediate on `resetn` low):
  - state `ARB_IDLE`, `grant` 0, `last_grant` NUM_PORTS−1, so port 0 wins first.
  - All outputs 0: `s_axis_tready` 0, `m_axis_tvalid` 0, `m_axis_tdata` 0, `m_axis_tlast` 0, `m_axis_tid` 0.
- **Reset mid-packet:** the partial packet is discarded and the registered output beat is dropped. Recovery is not the arbiter's concern.

## Timing
- **Arbitration latency:** requester valid in cycle 0 (IDLE) → ready in cycle 1 → first beat on `m_axis` in cycle 2.
- **Throughput:** 1 beat/cycle within a packet while `m_axis_tready` is held high.
- **Packet gap:** exactly one IDLE cycle between packets, including back-to-back packets from the same port.
- `s_axis_tready` is combinational from state, grant, `m_axis_tvalid` and `m_axis_tready`. It never depends on `s_axis_tvalid`.
- Single-beat packet (tlast on first beat): BUSY lasts 1 cycle if accepted immediately.
- Simultaneous tlast accept and new requests: the new arbitration happens in the following IDLE cycle, using the updated `last_grant`.

## Structure
- Package `crossbar_pkg` holds:
  - the `arb_state_t` enum (`ARB_IDLE`, `ARB_BUSY`);
  - a function computing ID_WIDTH as max(1, clog2(N)).
- Sub-module `crossbar_rr_picker`: combinational rotating priority select.
  - Inputs: req[NUM_PORTS], last_grant.
  - Outputs: any_req, pick index.
  - Reused by later multi-output crossbar arbiters.

## Test plan
- **Single port:** port 2 sends 3-beat packet 0xA0,0xA1,0xA2(last), with `m_axis_tready`=1.
  - Ready[2] high in cycles 1–3.
  - m_axis shows A0–A2, tid=2, tlast on A2 only, starting in cycle 2.
- **All ports contend:** all 4 ports continuously offer 2-beat packets from reset.
  - Output tid order 0,1,2,3,0,1…
  - One bubble cycle between packets.
- **Mid-packet contention:** port 1 is granted mid-packet while port 0 asserts valid.
  - Port 1's packet completes uninterrupted (ready[0]=0 throughout).
  - The next grant goes to port 2 if requesting, else port 3, else port 0.
- **Backpressure:** `m_axis_tready`=0 for 5 cycles after the first beat 0x55.
  - m_axis holds 0x55 with tvalid=1.
  - ready[grant]=0 for those cycles, and no beat is lost or duplicated.
- **Source gaps:** the granted port drops tvalid for 3 cycles mid-packet.
  - Grant is held, no other port is served, and the packet resumes intact.
- **Async reset:** assert `resetn`=0 mid-packet without a clock edge.
  - All outputs go to 0 immediately.
  - After release, port 0 is the first granted.
